// File: rtl/gs_pkg.sv
// Shared types for the gs_* arbitration blocks.
package gs_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/gs_arb_mux_if.sv
// Handshake bundle for gs_arb_mux: N request channels in, one registered beat out.
interface gs_arb_mux_if #(
  parameter int N_IN       = 3,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = $clog2(N_IN);

  logic [N_IN-1:0]       in_valid;
  logic [DATA_WIDTH-1:0] in_data [N_IN];
  logic [N_IN-1:0]       in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [SEL_WIDTH-1:0]  out_sel;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/gs_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module gs_rr_arbiter #(
  parameter int N_IN      = 3,
  parameter int SEL_WIDTH = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]      req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [N_IN-1:0]      gnt
);

  logic [2*N_IN-1:0] req_dbl;
  logic              found;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-index search over positions at or above ptr.
  always_comb begin
    req_dbl = {req, req};
    gnt     = '0;
    found   = 1'b0;
    for (int i = 0; i < 2 * N_IN; i++) begin
      if (!found && req_dbl[i] && (i >= int'(ptr))) begin
        gnt[i % N_IN] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gs_arb_mux.sv
// N-input arbitrated mux with a single registered output beat and valid/ready on every port.
module gs_arb_mux
  import gs_pkg::*;
#(
  parameter int        N_IN       = 3,
  parameter int        DATA_WIDTH = 32,
  parameter arb_mode_e ARB_MODE   = ARB_RR
) (
  input logic         clk,
  input logic         rst,
  gs_arb_mux_if.slave bus
);

  localparam int                   SEL_WIDTH = $clog2(N_IN);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(N_IN - 1);

  function automatic logic [SEL_WIDTH-1:0] onehot_to_idx(input logic [N_IN-1:0] oh);
    logic [SEL_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (oh[i]) idx = idx | SEL_WIDTH'(i);
    end
    return idx;
  endfunction

  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;

  logic [N_IN-1:0]       rr_gnt;
  logic [N_IN-1:0]       fixed_gnt;
  logic [N_IN-1:0]       grant;
  logic [N_IN-1:0]       ready;
  logic                  can_load;
  logic                  xfer;
  logic [SEL_WIDTH-1:0]  win_idx;

  gs_rr_arbiter #(
    .N_IN      (N_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_arbiter (
    .req (bus.in_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  always_comb begin
    fixed_gnt = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) fixed_gnt = N_IN'(1) << i;
    end
  end

  // The output register can take a new beat when empty or being drained this cycle.
  always_comb begin
    grant    = (ARB_MODE == ARB_RR) ? rr_gnt : fixed_gnt;
    can_load = !out_valid_q || bus.out_ready;
    ready    = (can_load && !rst) ? grant : '0;
    xfer     = |ready;
    win_idx  = onehot_to_idx(ready);
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[win_idx];
      out_sel_d   = win_idx;
      if (ARB_MODE == ARB_RR) begin
        ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else begin
        ptr_d = '0;
      end
    end else if (can_load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  a_ready_onehot0: assert property (@(posedge clk) $onehot0(ready));

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=> ($stable(out_data_q) && $stable(out_sel_q)));

  a_sel_range: assert property (@(posedge clk) int'(out_sel_q) < N_IN);

endmodule

// File: tb/tb_gs_arb_mux.sv
// Self-checking bench for gs_arb_mux: three instances (RR/3, FIXED/3, RR/5) against a queue-free behavioural model.
module tb_gs_arb_mux;
  import gs_pkg::*;

  localparam int D_RR3 = 0;
  localparam int D_FX3 = 1;
  localparam int D_RR5 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit hold_en  = 1'b0;

  gs_arb_mux_if #(.N_IN(3), .DATA_WIDTH(32)) bus_rr3 ();
  gs_arb_mux_if #(.N_IN(3), .DATA_WIDTH(32)) bus_fx3 ();
  gs_arb_mux_if #(.N_IN(5), .DATA_WIDTH(32)) bus_rr5 ();

  gs_arb_mux #(.N_IN(3), .DATA_WIDTH(32), .ARB_MODE(ARB_RR))
    dut_rr3 (.clk(clk), .rst(rst), .bus(bus_rr3));
  gs_arb_mux #(.N_IN(3), .DATA_WIDTH(32), .ARB_MODE(ARB_FIXED))
    dut_fx3 (.clk(clk), .rst(rst), .bus(bus_fx3));
  gs_arb_mux #(.N_IN(5), .DATA_WIDTH(32), .ARB_MODE(ARB_RR))
    dut_rr5 (.clk(clk), .rst(rst), .bus(bus_rr5));

  // Drive side, indexed by instance.
  logic [4:0]  drv_valid  [3];
  logic [31:0] drv_data   [3][5];
  logic        drv_oready [3];

  // Observed side, widened so every instance compares the same way.
  logic [4:0]  obs_ready [3];
  logic        obs_valid [3];
  logic [31:0] obs_data  [3];
  int          obs_sel   [3];

  // Reference model state.
  int          n_of  [3] = '{3, 3, 5};
  bit          rr_of [3] = '{1'b1, 1'b0, 1'b1};
  logic [4:0]  exp_ready [3];
  logic        exp_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] exp_data  [3] = '{32'h0, 32'h0, 32'h0};
  int          exp_sel   [3] = '{0, 0, 0};
  int          exp_ptr   [3] = '{0, 0, 0};
  logic        nxt_valid [3];
  logic [31:0] nxt_data  [3];
  int          nxt_sel   [3];
  int          nxt_ptr   [3];

  always_comb begin
    bus_rr3.in_valid  = drv_valid[D_RR3][2:0];
    bus_fx3.in_valid  = drv_valid[D_FX3][2:0];
    bus_rr5.in_valid  = drv_valid[D_RR5];
    bus_rr3.out_ready = drv_oready[D_RR3];
    bus_fx3.out_ready = drv_oready[D_FX3];
    bus_rr5.out_ready = drv_oready[D_RR5];
    for (int i = 0; i < 3; i++) begin
      bus_rr3.in_data[i] = drv_data[D_RR3][i];
      bus_fx3.in_data[i] = drv_data[D_FX3][i];
    end
    for (int i = 0; i < 5; i++) bus_rr5.in_data[i] = drv_data[D_RR5][i];
  end

  always_comb begin
    obs_ready[D_RR3] = {2'b00, bus_rr3.in_ready};
    obs_ready[D_FX3] = {2'b00, bus_fx3.in_ready};
    obs_ready[D_RR5] = bus_rr5.in_ready;
    obs_valid[D_RR3] = bus_rr3.out_valid;
    obs_valid[D_FX3] = bus_fx3.out_valid;
    obs_valid[D_RR5] = bus_rr5.out_valid;
    obs_data[D_RR3]  = bus_rr3.out_data;
    obs_data[D_FX3]  = bus_fx3.out_data;
    obs_data[D_RR5]  = bus_rr5.out_data;
    obs_sel[D_RR3]   = int'(bus_rr3.out_sel);
    obs_sel[D_FX3]   = int'(bus_fx3.out_sel);
    obs_sel[D_RR5]   = int'(bus_rr5.out_sel);
  end

  // Producers must keep an unaccepted request stable; checked while random traffic runs.
  for (genvar g = 0; g < 3; g++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (rst || !hold_en)
      (bus_rr3.in_valid[g] && !bus_rr3.in_ready[g]) |=>
      (bus_rr3.in_valid[g] && $stable(bus_rr3.in_data[g])));
  end

  // Winner by walking channels in priority order: from the pointer with wrap for RR, from 0 for fixed.
  function automatic int pick(input logic [4:0] v, input int ptr, input int n, input bit rr);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = rr ? (ptr + k) % n : k;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_comb();
    for (int k = 0; k < 3; k++) begin
      int w;
      bit room;
      w    = pick(drv_valid[k], exp_ptr[k], n_of[k], rr_of[k]);
      room = !exp_valid[k] || drv_oready[k];
      exp_ready[k] = (!rst && room && w >= 0) ? 5'(1 << w) : 5'b0;
      nxt_valid[k] = exp_valid[k];
      nxt_data[k]  = exp_data[k];
      nxt_sel[k]   = exp_sel[k];
      nxt_ptr[k]   = exp_ptr[k];
      if (rst) begin
        nxt_valid[k] = 1'b0;
        nxt_data[k]  = 32'h0;
        nxt_sel[k]   = 0;
        nxt_ptr[k]   = 0;
      end else if (room && w >= 0) begin
        nxt_valid[k] = 1'b1;
        nxt_data[k]  = drv_data[k][w];
        nxt_sel[k]   = w;
        nxt_ptr[k]   = rr_of[k] ? (w + 1) % n_of[k] : 0;
      end else if (room) begin
        nxt_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_valid[k] = nxt_valid[k];
      exp_data[k]  = nxt_data[k];
      exp_sel[k]   = nxt_sel[k];
      exp_ptr[k]   = nxt_ptr[k];
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin
      drv_valid[k]  = 5'b0;
      drv_oready[k] = 1'b1;
      for (int i = 0; i < 5; i++) drv_data[k][i] = $urandom;
    end
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      settle();
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    drv_valid[D_RR3] = 5'b00111;
    drv_valid[D_FX3] = 5'b00111;
    drv_valid[D_RR5] = 5'b11111;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_ready[k] !== 5'b0) begin
          failures++;
          $display("[TB] FAIL reset_in_ready dut=%0d got=%b exp=00000", k, obs_ready[k]);
        end
      end
      advance();
    end
    rst = 1'b0;
    settle();
    checks++;
    if (obs_valid[D_RR3] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b exp=0", obs_valid[D_RR3]);
    end
    checks++;
    if (obs_data[D_RR3] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_out_data got=%h exp=00000000", obs_data[D_RR3]);
    end
    checks++;
    if (obs_sel[D_RR3] !== 0) begin
      failures++;
      $display("[TB] FAIL reset_out_sel got=%0d exp=0", obs_sel[D_RR3]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_ready[k] !== 5'b00001) begin
        failures++;
        $display("[TB] FAIL first_grant dut=%0d got=%b exp=00001", k, obs_ready[k]);
      end
    end
    advance();
  endtask

  task automatic test_rr_stream();
    do_reset(1);
    drv_valid[D_RR3] = 5'b00111;
    for (int i = 0; i < 3; i++) drv_data[D_RR3][i] = 32'hA0 + 32'(i);
    for (int c = 0; c < 8; c++) begin
      settle();
      checks++;
      if (obs_ready[D_RR3] !== 5'(1 << (c % 3)) || obs_ready[D_RR3] !== exp_ready[D_RR3]) begin
        failures++;
        $display("[TB] FAIL stream_in_ready c=%0d got=%b exp=%b", c, obs_ready[D_RR3], exp_ready[D_RR3]);
      end
      checks++;
      if (obs_valid[D_RR3] !== (c != 0)) begin
        failures++;
        $display("[TB] FAIL stream_out_valid c=%0d got=%b exp=%b", c, obs_valid[D_RR3], c != 0);
      end
      if (c != 0) begin
        checks++;
        if (obs_sel[D_RR3] !== (c - 1) % 3 || obs_data[D_RR3] !== 32'hA0 + 32'((c - 1) % 3)) begin
          failures++;
          $display("[TB] FAIL stream_beat c=%0d got sel=%0d data=%h exp sel=%0d", c, obs_sel[D_RR3], obs_data[D_RR3], (c - 1) % 3);
        end
      end
      advance();
    end
  endtask

  task automatic test_fixed_starve();
    do_reset(1);
    drv_valid[D_FX3] = 5'b00110;
    for (int i = 0; i < 3; i++) drv_data[D_FX3][i] = 32'hB0 + 32'(i);
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if (obs_ready[D_FX3] !== 5'b00010) begin
        failures++;
        $display("[TB] FAIL fixed_in_ready c=%0d got=%b exp=00010", c, obs_ready[D_FX3]);
      end
      if (c != 0) begin
        checks++;
        if (obs_valid[D_FX3] !== 1'b1 || obs_sel[D_FX3] !== 1 || obs_data[D_FX3] !== 32'hB1) begin
          failures++;
          $display("[TB] FAIL fixed_beat c=%0d got v=%b sel=%0d data=%h exp v=1 sel=1 data=b1", c, obs_valid[D_FX3], obs_sel[D_FX3], obs_data[D_FX3]);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_pressure();
    do_reset(1);
    drv_valid[D_RR3]   = 5'b00100;
    drv_data[D_RR3][2] = 32'hDEAD_BEEF;
    settle();
    checks++;
    if (obs_ready[D_RR3] !== 5'b00100) begin
      failures++;
      $display("[TB] FAIL bp_load_ready got=%b exp=00100", obs_ready[D_RR3]);
    end
    advance();
    drv_valid[D_RR3]   = 5'b00001;
    drv_data[D_RR3][0] = 32'h0000_0011;
    drv_oready[D_RR3]  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (obs_ready[D_RR3] !== 5'b0) begin
        failures++;
        $display("[TB] FAIL bp_stall_ready c=%0d got=%b exp=00000", c, obs_ready[D_RR3]);
      end
      checks++;
      if (obs_valid[D_RR3] !== 1'b1 || obs_data[D_RR3] !== 32'hDEAD_BEEF || obs_sel[D_RR3] !== 2) begin
        failures++;
        $display("[TB] FAIL bp_stall_hold c=%0d got v=%b data=%h sel=%0d exp v=1 data=deadbeef sel=2", c, obs_valid[D_RR3], obs_data[D_RR3], obs_sel[D_RR3]);
      end
      advance();
    end
    drv_oready[D_RR3] = 1'b1;
    settle();
    checks++;
    if (obs_ready[D_RR3] !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL bp_release_ready got=%b exp=00001", obs_ready[D_RR3]);
    end
    advance();
    drv_valid[D_RR3] = 5'b0;
    settle();
    checks++;
    if (obs_valid[D_RR3] !== 1'b1 || obs_data[D_RR3] !== 32'h0000_0011 || obs_sel[D_RR3] !== 0) begin
      failures++;
      $display("[TB] FAIL bp_no_bubble got v=%b data=%h sel=%0d exp v=1 data=00000011 sel=0", obs_valid[D_RR3], obs_data[D_RR3], obs_sel[D_RR3]);
    end
    advance();
  endtask

  task automatic test_wrap();
    do_reset(1);
    drv_valid[D_RR5]   = 5'b10000;
    drv_data[D_RR5][4] = 32'h44;
    settle();
    checks++;
    if (obs_ready[D_RR5] !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL wrap_ch4_ready got=%b exp=10000", obs_ready[D_RR5]);
    end
    advance();
    drv_valid[D_RR5]   = 5'b01001;
    drv_data[D_RR5][0] = 32'h40;
    drv_data[D_RR5][3] = 32'h43;
    settle();
    checks++;
    if (obs_ready[D_RR5] !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL wrap_ch0_first got=%b exp=00001", obs_ready[D_RR5]);
    end
    checks++;
    if (obs_sel[D_RR5] !== 4 || obs_data[D_RR5] !== 32'h44) begin
      failures++;
      $display("[TB] FAIL wrap_beat4 got sel=%0d data=%h exp sel=4 data=44", obs_sel[D_RR5], obs_data[D_RR5]);
    end
    advance();
    drv_valid[D_RR5] = 5'b01000;
    settle();
    checks++;
    if (obs_sel[D_RR5] !== 0 || obs_data[D_RR5] !== 32'h40 || obs_ready[D_RR5] !== 5'b01000) begin
      failures++;
      $display("[TB] FAIL wrap_beat0 got sel=%0d data=%h ready=%b exp sel=0 data=40 ready=01000", obs_sel[D_RR5], obs_data[D_RR5], obs_ready[D_RR5]);
    end
    advance();
  endtask

  task automatic test_idle_drain();
    int high;
    do_reset(1);
    drv_valid[D_RR3]   = 5'b00010;
    drv_data[D_RR3][1] = 32'h77;
    settle();
    advance();
    drv_valid[D_RR3] = 5'b0;
    high = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (obs_valid[D_RR3] === 1'b1) high++;
      checks++;
      if (obs_data[D_RR3] !== 32'h77 || obs_sel[D_RR3] !== 1) begin
        failures++;
        $display("[TB] FAIL drain_hold c=%0d got data=%h sel=%0d exp data=77 sel=1", c, obs_data[D_RR3], obs_sel[D_RR3]);
      end
      advance();
    end
    checks++;
    if (high !== 1) begin
      failures++;
      $display("[TB] FAIL drain_valid_cycles got=%0d exp=1", high);
    end
    drv_valid[D_RR3]   = 5'b00001;
    drv_data[D_RR3][0] = 32'h55;
    settle();
    advance();
    drv_valid[D_RR3]  = 5'b0;
    drv_oready[D_RR3] = 1'b0;
    settle();
    advance();
    rst = 1'b1;
    settle();
    checks++;
    if (obs_valid[D_RR3] !== 1'b1 || obs_data[D_RR3] !== 32'h55) begin
      failures++;
      $display("[TB] FAIL midreset_pending got v=%b data=%h exp v=1 data=55", obs_valid[D_RR3], obs_data[D_RR3]);
    end
    advance();
    rst = 1'b0;
    drv_oready[D_RR3] = 1'b1;
    drv_valid[D_RR3]  = 5'b00111;
    settle();
    checks++;
    if (obs_valid[D_RR3] !== 1'b0 || obs_data[D_RR3] !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_discard got v=%b data=%h exp v=0 data=0", obs_valid[D_RR3], obs_data[D_RR3]);
    end
    checks++;
    if (obs_ready[D_RR3] !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL midreset_ptr got=%b exp=00001", obs_ready[D_RR3]);
    end
    advance();
  endtask

  task automatic test_random();
    logic [4:0] acc [3];
    do_reset(1);
    hold_en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      settle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_ready[k] !== exp_ready[k] || obs_valid[k] !== exp_valid[k] ||
            obs_data[k] !== exp_data[k] || obs_sel[k] !== exp_sel[k]) begin
          failures++;
          $display("[TB] FAIL random c=%0d dut=%0d got rdy=%b v=%b d=%h s=%0d exp rdy=%b v=%b d=%h s=%0d",
                   c, k, obs_ready[k], obs_valid[k], obs_data[k], obs_sel[k],
                   exp_ready[k], exp_valid[k], exp_data[k], exp_sel[k]);
        end
        acc[k] = drv_valid[k] & exp_ready[k];
      end
      advance();
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < n_of[k]; i++) begin
          if (!(drv_valid[k][i] && !acc[k][i])) begin
            drv_valid[k][i] = ($urandom_range(0, 2) != 0);
            drv_data[k][i]  = $urandom;
          end
        end
        drv_oready[k] = ($urandom_range(0, 3) != 0);
      end
    end
    hold_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_rr_stream();
    test_fixed_starve();
    test_back_pressure();
    test_wrap();
    test_idle_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
